// File: rtl/dcp_pkg.sv
// Shared definitions for the serial debug unit: print type codes, ASCII constants
// and the print_tx state encoding.
package dcp_pkg;

  localparam logic [1:0] PT_CHAR = 2'b00;
  localparam logic [1:0] PT_BYTE = 2'b01;
  localparam logic [1:0] PT_WORD = 2'b10;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } pt_state_t;

endpackage

// File: rtl/hex2ascii.sv
// Nibble to uppercase ASCII hex digit; purely combinational, no handshake.
module hex2ascii (
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  always_comb begin
    asc = 8'h00;
    if (nib < 4'd10) asc = 8'h30 + {4'h0, nib};
    else             asc = 8'h37 + {4'h0, nib};  // 'A' - 10
  end

endmodule

// File: rtl/print_tx.sv
// Formats a char/byte/word as uppercase hex (+ optional suffix) onto a byte stream.
// First byte one cycle after acceptance, no bubbles; rdy_tx low stalls with d_tx held.
module print_tx
  import dcp_pkg::*;
#(
  parameter bit SEP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic [1:0]  type_tx,
  input  logic [31:0] dout_tx,
  input  logic [7:0]  sep_tx,
  output logic        ack_tx,
  output logic        busy_tx,
  input  logic        rdy_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx
);

  pt_state_t   state;
  logic [31:0] shreg;
  logic [3:0]  cnt;
  logic [7:0]  sep_q;
  logic        sep_sent;

  logic [3:0]  first_nib;
  logic [7:0]  first_asc;
  logic [7:0]  next_asc;
  logic        xfer;
  logic        last_xfer;

  // A byte value is left-aligned in the shift register so both widths read the top nibble.
  assign first_nib = (type_tx == PT_BYTE) ? dout_tx[7:4] : dout_tx[31:28];
  assign xfer      = vld_tx && rdy_tx;
  assign last_xfer = sep_sent || (cnt == 4'd1 && sep_q == 8'h00);

  hex2ascii u_hex_first (
    .nib (first_nib),
    .asc (first_asc)
  );

  hex2ascii u_hex_next (
    .nib (shreg[27:24]),
    .asc (next_asc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= 32'h0;
      cnt      <= 4'd0;
      sep_q    <= 8'h00;
      sep_sent <= 1'b0;
      d_tx     <= 8'h00;
      vld_tx   <= 1'b0;
      ack_tx   <= 1'b0;
      busy_tx  <= 1'b0;
    end else begin
      ack_tx <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_tx) begin
            state    <= ST_SEND;
            vld_tx   <= 1'b1;
            busy_tx  <= 1'b1;
            sep_sent <= 1'b0;
            sep_q    <= SEP_EN ? sep_tx : 8'h00;
            case (type_tx)
              PT_CHAR: begin
                shreg <= {dout_tx[7:0], 24'h0};
                cnt   <= 4'd1;
                d_tx  <= dout_tx[7:0];
              end
              PT_BYTE: begin
                shreg <= {dout_tx[7:0], 24'h0};
                cnt   <= 4'd2;
                d_tx  <= first_asc;
              end
              default: begin
                shreg <= dout_tx;
                cnt   <= 4'd8;
                d_tx  <= first_asc;
              end
            endcase
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (last_xfer) begin
              state  <= ST_DONE;
              vld_tx <= 1'b0;
              d_tx   <= 8'h00;
              ack_tx <= 1'b1;
            end else if (cnt > 4'd1) begin
              shreg <= shreg << 4;
              cnt   <= cnt - 4'd1;
              d_tx  <= next_asc;
            end else begin
              d_tx     <= sep_q;
              sep_sent <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          busy_tx <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_print_tx.sv
// Directed bench for print_tx: hand-computed byte streams, ack timing, stalls and reset abort.
module tb_print_tx;
  import dcp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_tx;
  logic [1:0]  type_tx;
  logic [31:0] dout_tx;
  logic [7:0]  sep_tx;
  logic        ack_tx;
  logic        busy_tx;
  logic        rdy_tx;
  logic [7:0]  d_tx;
  logic        vld_tx;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  got_q[$];
  int          gcyc_q[$];
  logic [7:0]  exp_q[$];
  int          ack_cnt;
  int          ack_k;
  int          stall_bad;
  logic        idle_ok;
  logic [63:0] busy_mask;

  print_tx #(.SEP_EN(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_tx  (req_tx),
    .type_tx (type_tx),
    .dout_tx (dout_tx),
    .sep_tx  (sep_tx),
    .ack_tx  (ack_tx),
    .busy_tx (busy_tx),
    .rdy_tx  (rdy_tx),
    .d_tx    (d_tx),
    .vld_tx  (vld_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mode 0: rdy high; 1: rdy low for the first 5 valid cycles; 2: rdy toggles; 3: new req mid-send
  task automatic run(input logic [1:0] t, input logic [31:0] v, input logic [7:0] s, input int mode);
    req_tx = 1'b1; type_tx = t; dout_tx = v; sep_tx = s; rdy_tx = 1'b1;
    cyc();
    req_tx = 1'b0; dout_tx = 32'h5A5A5A5A; type_tx = PT_CHAR; sep_tx = 8'h2A;
    got_q.delete(); gcyc_q.delete();
    ack_cnt = 0; ack_k = 0; stall_bad = 0; idle_ok = 1'b0; busy_mask = '0;
    for (int k = 1; k <= 60; k++) begin
      case (mode)
        1:       rdy_tx = (k > 5);
        2:       rdy_tx = k[0];
        default: rdy_tx = 1'b1;
      endcase
      if (mode == 3 && k == 3) begin
        req_tx = 1'b1; dout_tx = 32'hFFFFFFFF; type_tx = PT_WORD; sep_tx = 8'h00;
      end
      if (mode == 3 && k == 4) req_tx = 1'b0;
      if (busy_tx) busy_mask[k] = 1'b1;
      if (mode == 1 && k <= 5 && !(vld_tx && d_tx == 8'h4F)) stall_bad++;
      if (vld_tx && rdy_tx) begin
        got_q.push_back(d_tx);
        gcyc_q.push_back(k);
      end
      if (ack_tx) begin
        ack_cnt++;
        ack_k = k;
      end
      if (ack_k != 0 && k == ack_k + 1) begin
        idle_ok = !vld_tx && !busy_tx && !ack_tx;
        break;
      end
      cyc();
    end
    req_tx = 1'b0;
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({tag, "_byte"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
  endtask

  initial begin
    rst = 1'b1; req_tx = 1'b0; type_tx = PT_CHAR; dout_tx = '0; sep_tx = '0; rdy_tx = 1'b1;
    cyc(); cyc();
    chk("rst_d", d_tx, 0);
    chk("rst_vld", vld_tx, 0);
    chk("rst_ack", ack_tx, 0);
    chk("rst_busy", busy_tx, 0);
    rst = 1'b0;
    cyc();

    // Word with space suffix, rdy always high
    run(PT_WORD, 32'h1234ABCD, ASC_SP, 0);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20};
    check_bytes("word");
    for (int i = 0; i < gcyc_q.size(); i++) chk("word_cycle", gcyc_q[i], i + 1);
    chk("word_ack_k", ack_k, 10);
    chk("word_ack_cnt", ack_cnt, 1);
    chk("word_busy", busy_mask, 64'h7FE);
    chk("word_idle", idle_ok, 1);

    // Byte, no suffix, issued at the earliest legal cycle
    run(PT_BYTE, 32'h0000000F, 8'h00, 0);
    exp_q = '{8'h30, 8'h46};
    check_bytes("byte");
    chk("byte_ack_k", ack_k, 3);
    chk("byte_busy", busy_mask, 64'hE);
    chk("byte_idle", idle_ok, 1);

    // Raw char with LF suffix, stalled for 5 cycles
    run(PT_CHAR, 32'h0000004F, ASC_LF, 1);
    exp_q = '{8'h4F, 8'h0A};
    check_bytes("char");
    chk("char_stall", stall_bad, 0);
    chk("char_ack_k", ack_k, 8);
    chk("char_ack_cnt", ack_cnt, 1);

    // Request during SEND must be ignored
    run(PT_WORD, 32'hDEADBEEF, ASC_CR, 3);
    exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D};
    check_bytes("inject");
    chk("inject_ack_cnt", ack_cnt, 1);
    chk("inject_idle", idle_ok, 1);

    // Reset after three digits
    req_tx = 1'b1; type_tx = PT_WORD; dout_tx = 32'h89ABCDEF; sep_tx = 8'h00; rdy_tx = 1'b1;
    cyc();
    req_tx = 1'b0;
    exp_q = '{8'h38, 8'h39, 8'h41};
    for (int k = 0; k < 3; k++) begin
      chk("abort_vld", vld_tx, 1);
      chk("abort_byte", d_tx, exp_q[k]);
      cyc();
    end
    rst = 1'b1;
    cyc();
    chk("abort_d", d_tx, 0);
    chk("abort_vld0", vld_tx, 0);
    chk("abort_ack", ack_tx, 0);
    chk("abort_busy", busy_tx, 0);
    rst = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (ack_tx || vld_tx) ack_cnt++;
      cyc();
    end
    chk("abort_quiet", ack_cnt, 0);
    run(PT_WORD, 32'h89ABCDEF, 8'h00, 0);
    exp_q = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    check_bytes("restart");
    chk("restart_ack_cnt", ack_cnt, 1);

    // rdy toggling on an all-zero word
    run(PT_WORD, 32'h00000000, 8'h00, 2);
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
    check_bytes("toggle");
    chk("toggle_ack_k", ack_k, 16);
    chk("toggle_ack_cnt", ack_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/print_tx.md
# print_tx

Transmit-side formatter for the serial debug unit, the counterpart of the receive-side scanner. A command module hands it one value per request: a raw character, a byte, or a 32-bit word. It converts the value to uppercase ASCII hex, MSB nibble first, and feeds the bytes one at a time to the UART transmitter over the `vld_tx`/`rdy_tx` handshake. It then pulses `ack_tx` so the issuing command module (register/memory dump, breakpoint report) can queue the next item.

## Interface
- `SEP_EN`, 1: enables the optional suffix byte `sep_tx`; when 0, `sep_tx` is ignored.
- `clk` in 1: single clock, shared with the UART and the command modules.
- `rst` in 1: synchronous, active-high reset.
- `req_tx` in 1: request; sampled only in IDLE.
- `type_tx` in 2: 00 = raw char `dout_tx[7:0]`; 01 = 2 hex digits of `dout_tx[7:0]`; 10 or 11 = 8 hex digits of `dout_tx[31:0]`.
- `dout_tx` in 32: value to print.
- `sep_tx` in 8: suffix byte sent after the value; 8'h00 = no suffix.
- `ack_tx` out 1: one-cycle pulse when the last byte has been accepted.
- `busy_tx` out 1: high from the cycle after acceptance until `ack_tx`, inclusive.
- `rdy_tx` in 1: UART transmitter ready.
- `d_tx` out 8: byte to transmit.
- `vld_tx` out 1: `d_tx` valid.

## Operation
- States: IDLE, SEND, DONE.
- IDLE: `vld_tx`=0 and `busy_tx`=0. On `req_tx`=1, latch `dout_tx`, `type_tx`, and `sep_tx` (or 0 when `SEP_EN`=0). Set the digit counter to 1/2/8 by type, clear the suffix-sent flag, and go to SEND.
- SEND:
  - `vld_tx`=1. `d_tx` = current character: raw byte, or hex of the top nibble of the latched shift register.
  - A transfer occurs in any cycle with `vld_tx && rdy_tx`.
  - On transfer with counter > 1: shift the register left by 4 and decrement the counter.
  - On transfer of the last digit: if the latched sep ≠ 0 and the suffix is not yet sent, present sep next and set the flag. Otherwise go to DONE.
  - On transfer of the suffix: go to DONE.
- DONE: `vld_tx`=0, `ack_tx`=1 for exactly one cycle, then IDLE.
- Hex map: nibble 0–9 → 8'h30+n; 10–15 → 8'h41+(n−10). Uppercase only.
- `req_tx` while not in IDLE: ignored, not queued. A `req_tx` held high in DONE is not accepted until the IDLE cycle.
- Input changes after acceptance have no effect; all values are latched.
- Reset value of every output: `d_tx`=0, `vld_tx`=0, `ack_tx`=0, `busy_tx`=0; state IDLE.
- Reset mid-transfer: abort on the next edge, no `ack_tx`, remaining bytes discarded.

## Timing
- All outputs are registered; no combinational path from `rdy_tx` or `req_tx` to outputs.
- Request accepted at edge t: `vld_tx`=1 with the first byte from cycle t+1.
- Each byte holds `d_tx` stable with `vld_tx` high until the transfer cycle. The next byte appears the following cycle with `vld_tx` still high, so back-to-back bytes have no bubble.
- With `rdy_tx` constantly 1 and N bytes (value plus suffix): bytes in cycles t+1..t+N, `ack_tx` at t+N+1, IDLE at t+N+2. The earliest next acceptance is t+N+2.
- `vld_tx` never drops while a byte is pending. `rdy_tx` deassertion stalls without loss or duplication.

## Structure
- Shared package `dcp_pkg`:
  - Type codes `PT_CHAR`=2'b00, `PT_BYTE`=2'b01, `PT_WORD`=2'b10.
  - ASCII constants `ASC_SP`=8'h20, `ASC_CR`=8'h0D, `ASC_LF`=8'h0A.
  - State encodings.
- One sub-module `hex2ascii`: a combinational 4-bit → 8-bit converter.
- Everything else (counter, shift register, FSM) lives in `print_tx`.

## Test plan
- Word 32'h1234ABCD, type 10, sep 8'h20, `rdy_tx`=1: bytes 31 32 33 34 41 42 43 44 20 in consecutive cycles t+1..t+9, `ack_tx` at t+10 only.
- Byte 8'h0F, type 01, sep 0: bytes 30 46, `ack_tx` at t+3, `busy_tx` high t+1..t+3.
- Char 8'h4F ('O'), type 00, sep 8'h0A, with `rdy_tx` low for 5 cycles after `vld_tx` rises: `d_tx`=4F held stable throughout, then 0A, then one `ack_tx`.
- `req_tx` pulsed during SEND with new data 32'hFFFFFFFF: ignored; the original output completes unchanged, and exactly one `ack_tx` occurs.
- `rst` asserted after 3 of 8 digits: the next cycle has all outputs 0 and state IDLE, no `ack_tx`. A new request then prints all 8 digits from the first.
- `rdy_tx` toggling 1/0 every cycle on word 32'h00000000: exactly eight 8'h30 transfers, no duplicates or drops.
